// File: rtl/fir_pkg.sv
// Shared constants and types for the parallel FIR datapath.
// Samples are Q15 integers; accumulators carry Q1.31 coefficient products.
package fir_pkg;
    localparam int LANES     = 3;
    localparam int SAMPLE_W  = 16;
    localparam int ACC_W     = 64;
    localparam int COEF_FRAC = 31;
    localparam int BLK_DEPTH = 2;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    localparam sample_t SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

    // Block-buffer occupancy, exposed as the serializer's state.
    typedef enum logic [1:0] {
        OCC_EMPTY  = 2'd0,
        OCC_STREAM = 2'd1,
        OCC_FULL   = 2'd2
    } occ_t;
endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and saturate of one accumulator lane to a sample.
// Arithmetic is one bit wider than the accumulator so the rounding add never wraps.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int IN_W  = ACC_W,
    parameter int OUT_W = SAMPLE_W,
    parameter int FRAC  = COEF_FRAC
) (
    input  logic signed [IN_W-1:0]  acc,
    output logic signed [OUT_W-1:0] sample,
    output logic                    sat
);
    localparam logic signed [IN_W:0]    HALF  = (IN_W+1)'(1) << (FRAC-1);
    localparam logic signed [IN_W:0]    HI    = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0]    LO    = -HI - (IN_W+1)'(1);
    localparam logic signed [OUT_W-1:0] MAX_S = OUT_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [OUT_W-1:0] MIN_S = ~MAX_S;

    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] shf;

    always_comb begin
        rnd    = {acc[IN_W-1], acc} + HALF;
        shf    = rnd >>> FRAC;
        sample = shf[OUT_W-1:0];
        sat    = 1'b0;
        if (shf > HI) begin
            sample = MAX_S;
            sat    = 1'b1;
        end else if (shf < LO) begin
            sample = MIN_S;
            sat    = 1'b1;
        end
    end
endmodule

// File: rtl/fir_parallel_serializer.sv
// Output stage of the 3-parallel FIR: rounds a block of lane results on entry,
// buffers up to DEPTH blocks and streams one sample per cycle, oldest lane first.
module fir_parallel_serializer #(
    parameter int LANES = fir_pkg::LANES,
    parameter int IN_W  = fir_pkg::ACC_W,
    parameter int OUT_W = fir_pkg::SAMPLE_W,
    parameter int FRAC  = fir_pkg::COEF_FRAC,
    parameter int DEPTH = fir_pkg::BLK_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    blk_valid,
    output logic                    blk_ready,
    input  logic [LANES*IN_W-1:0]   blk_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    input  logic                    sat_clr,
    output logic [15:0]             sat_count
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(LANES + 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    logic signed [OUT_W-1:0] buf_data [DEPTH][LANES];
    logic                    buf_sat  [DEPTH][LANES];
    logic signed [OUT_W-1:0] lane_sample [LANES];
    logic [LANES-1:0]        lane_sat;

    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  lane_idx;
    logic [CW-1:0]  count, count_nxt;
    fir_pkg::occ_t  occ_state, occ_nxt;
    logic           push, pop, pop_last;
    logic [SW-1:0]  blk_sat_n;
    logic [16:0]    sat_sum;
    logic [15:0]    sat_nxt;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fir_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC)) u_round_sat (
            .acc    (blk_data[k*IN_W +: IN_W]),
            .sample (lane_sample[k]),
            .sat    (lane_sat[k])
        );
    end

    // Valid/ready: a transfer happens on a rising edge where both are high. blk_ready
    // comes from registered occupancy only, so a full buffer ignores a same-cycle drain.
    assign blk_ready = (occ_state != fir_pkg::OCC_FULL);
    assign out_valid = (occ_state != fir_pkg::OCC_EMPTY);
    assign out_data  = buf_data[rd_ptr][lane_idx];
    assign out_sat   = buf_sat[rd_ptr][lane_idx];
    assign push      = blk_valid && blk_ready;
    assign pop       = out_valid && out_ready;
    assign pop_last  = pop && (lane_idx == LANE_LAST);

    always_comb begin
        count_nxt = count;
        if (push && !pop_last) begin
            count_nxt = count + CW'(1);
        end else if (pop_last && !push) begin
            count_nxt = count - CW'(1);
        end
        occ_nxt = fir_pkg::OCC_STREAM;
        if (count_nxt == '0) begin
            occ_nxt = fir_pkg::OCC_EMPTY;
        end else if (count_nxt == DEPTH_C) begin
            occ_nxt = fir_pkg::OCC_FULL;
        end
    end

    // Saturations are tallied when a block is accepted; a clear in the same cycle
    // restarts the tally from that block.
    always_comb begin
        blk_sat_n = '0;
        for (int k = 0; k < LANES; k++) begin
            blk_sat_n = blk_sat_n + SW'(lane_sat[k]);
        end
        sat_sum = {1'b0, (sat_clr ? 16'h0000 : sat_count)} + 17'(blk_sat_n);
        sat_nxt = sat_count;
        if (sat_clr) begin
            sat_nxt = '0;
        end
        if (push) begin
            sat_nxt = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_state <= fir_pkg::OCC_EMPTY;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lane_idx  <= '0;
            sat_count <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                for (int k = 0; k < LANES; k++) begin
                    buf_data[d][k] <= '0;
                    buf_sat[d][k]  <= 1'b0;
                end
            end
        end else begin
            occ_state <= occ_nxt;
            count     <= count_nxt;
            sat_count <= sat_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                for (int k = 0; k < LANES; k++) begin
                    buf_data[wr_ptr][k] <= lane_sample[k];
                    buf_sat[wr_ptr][k]  <= lane_sat[k];
                end
            end
            if (pop) begin
                lane_idx <= pop_last ? '0 : lane_idx + LW'(1);
            end
            if (pop_last) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end
endmodule
